// File: rtl/scytale_encryption_if.sv
// Handshake bundle for the scytale encryptor: plaintext in, ciphertext out.
// The master drives plaintext and keys; the slave (encryptor) drives the result.
interface scytale_encryption_if #(
    parameter int D_WIDTH   = 8,
    parameter int KEY_WIDTH = 8
);
    logic [D_WIDTH-1:0]   data_i;
    logic                 valid_i;
    logic [KEY_WIDTH-1:0] key_N;
    logic [KEY_WIDTH-1:0] key_M;
    logic [D_WIDTH-1:0]   data_o;
    logic                 valid_o;
    logic                 busy;

    modport master (
        output data_i, valid_i, key_N, key_M,
        input  data_o, valid_o, busy
    );

    modport slave (
        input  data_i, valid_i, key_N, key_M,
        output data_o, valid_o, busy
    );
endinterface

// File: rtl/scytale_encryption.sv
// Scytale transposition: collects a row-major message until the token,
// then emits it column-major over a key_M x key_N matrix, zero-padded.
module scytale_encryption #(
    parameter int                 D_WIDTH                = 8,
    parameter int                 KEY_WIDTH              = 8,
    parameter int                 MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0] START_ENCRYPTION_TOKEN = D_WIDTH'(8'hFA)
) (
    input  logic                clk,
    input  logic                rst,
    scytale_encryption_if.slave bus
);
    localparam int IW = 2 * KEY_WIDTH;
    localparam int LW = $clog2(MAX_NOF_CHARS + 1);
    localparam int AW = $clog2(MAX_NOF_CHARS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]           r_state;
    logic [D_WIDTH-1:0]   r_buf [MAX_NOF_CHARS];
    logic [LW-1:0]        r_len;
    logic [KEY_WIDTH-1:0] r_row;
    logic [KEY_WIDTH-1:0] r_col;
    logic [KEY_WIDTH-1:0] r_key_n;
    logic [KEY_WIDTH-1:0] r_key_m;
    logic [IW-1:0]        r_total;
    logic [IW-1:0]        r_cnt;
    logic [D_WIDTH-1:0]   r_data_o;
    logic                 r_valid_o;
    logic                 r_busy;

    logic                 w_tok_hit;
    logic                 w_char_hit;
    logic                 w_store;
    logic [IW-1:0]        w_src;
    logic [AW-1:0]        w_addr;
    logic                 w_pad;
    logic                 w_last_row;
    logic                 w_done;
    logic [IW-1:0]        w_total_in;

    assign w_tok_hit  = bus.valid_i && (bus.data_i == START_ENCRYPTION_TOKEN);
    assign w_char_hit = bus.valid_i && (bus.data_i != START_ENCRYPTION_TOKEN);
    assign w_store    = (r_state == ST_IDLE) && w_char_hit && (r_len < LW'(MAX_NOF_CHARS)) && !rst;
    assign w_total_in = IW'(bus.key_N) * IW'(bus.key_M);

    // Column-major walk: (r, c) counters replace k mod M / k div M.
    assign w_src      = IW'(r_row) * IW'(r_key_n) + IW'(r_col);
    assign w_addr     = AW'(w_src);
    assign w_pad      = (w_src >= IW'(r_len));
    assign w_last_row = (r_row == r_key_m - KEY_WIDTH'(1));
    assign w_done     = (r_cnt == r_total);

    always_ff @(posedge clk) begin
        if (w_store) r_buf[AW'(r_len)] <= bus.data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_key_n   <= '0;
            r_key_m   <= '0;
            r_total   <= '0;
            r_cnt     <= '0;
            r_data_o  <= '0;
            r_valid_o <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_valid_o <= 1'b0;
                    r_data_o  <= '0;
                    if (w_tok_hit) begin
                        r_key_n <= bus.key_N;
                        r_key_m <= bus.key_M;
                        r_total <= w_total_in;
                        r_cnt   <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_EMIT;
                    end else if (w_store) begin
                        r_len <= r_len + LW'(1);
                    end
                end
                default: begin
                    if (w_done) begin
                        r_valid_o <= 1'b0;
                        r_data_o  <= '0;
                        r_busy    <= 1'b0;
                        r_len     <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_valid_o <= 1'b1;
                        r_data_o  <= w_pad ? '0 : r_buf[w_addr];
                        r_cnt     <= r_cnt + IW'(1);
                        if (w_last_row) begin
                            r_row <= '0;
                            r_col <= r_col + KEY_WIDTH'(1);
                        end else begin
                            r_row <= r_row + KEY_WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.data_o  = r_data_o;
    assign bus.valid_o = r_valid_o;
    assign bus.busy    = r_busy;
endmodule

// File: tb/tb_scytale_encryption.sv
// Directed bench for scytale_encryption with hand-computed ciphertexts.
module tb_scytale_encryption;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    scytale_encryption_if #(.D_WIDTH(8), .KEY_WIDTH(8)) bus ();

    scytale_encryption #(
        .D_WIDTH(8), .KEY_WIDTH(8), .MAX_NOF_CHARS(50),
        .START_ENCRYPTION_TOKEN(8'hFA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bq_t str_q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Inputs change 1ns after the rising edge and are sampled on the next one.
    task automatic send_byte(input logic [7:0] b);
        bus.data_i  = b;
        bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;
    endtask

    task automatic send_msg(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic run_case(input string tag, input int n, input int m,
                            input bq_t exp, input bit noisy, input int abort_at);
        bq_t got;
        int  busy_cycles = 1;
        int  first_valid = -1;
        int  cyc = 0;
        bit  finished = 0;
        bus.key_N = 8'(n);
        bus.key_M = 8'(m);
        send_byte(8'hFA);
        check({tag, " busy after token"}, 32'(bus.busy), 32'd1);
        check({tag, " no valid on token"}, 32'(bus.valid_o), 32'd0);
        while (!finished && cyc < 200) begin
            if (noisy) begin
                bus.valid_i = 1'($urandom_range(1));
                bus.data_i  = ($urandom_range(3) == 0) ? 8'hFA : 8'($urandom);
                bus.key_N   = 8'($urandom);
                bus.key_M   = 8'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
            if (!bus.busy) finished = 1;
            else begin
                busy_cycles++;
                if (bus.valid_o) begin
                    if (first_valid < 0) first_valid = cyc;
                    got.push_back(bus.data_o);
                    if (got.size() == abort_at) begin
                        #1 rst = 1'b1;
                        #1;
                        check({tag, " async data_o"}, 32'(bus.data_o), 32'd0);
                        check({tag, " async valid_o"}, 32'(bus.valid_o), 32'd0);
                        check({tag, " async busy"}, 32'(bus.busy), 32'd0);
                        check({tag, " 3rd output before reset"}, 32'(got[2]), 32'h42);
                        #1 rst = 1'b0;
                        bus.valid_i = 1'b0;
                        return;
                    end
                end
            end
        end
        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;
        check({tag, " finished in budget"}, 32'(finished), 32'd1);
        check({tag, " output count"}, 32'(got.size()), 32'(exp.size()));
        check({tag, " busy cycles"}, 32'(busy_cycles), 32'(exp.size() + 1));
        if (exp.size() > 0) check({tag, " first valid latency"}, 32'(first_valid), 32'd1);
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s char %0d", tag, i), 32'(got[i]), 32'(exp[i]));
        check({tag, " valid_o low after"}, 32'(bus.valid_o), 32'd0);
        check({tag, " data_o zero after"}, 32'(bus.data_o), 32'd0);
    endtask

    initial begin
        bq_t exp;
        string long_msg;
        bus.data_i  = 8'h00;
        bus.valid_i = 1'b0;
        bus.key_N   = 8'd0;
        bus.key_M   = 8'd0;
        #12;
        check("reset data_o", 32'(bus.data_o), 32'd0);
        check("reset valid_o", 32'(bus.valid_o), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        send_msg("ABCDEF");
        run_case("abcdef", 3, 2, str_q("ADBECF"), 0, -1);

        send_msg("ABCD");
        exp = '{8'h41, 8'h44, 8'h42, 8'h00, 8'h43, 8'h00};
        run_case("abcd_pad", 3, 2, exp, 0, -1);

        send_msg("ABCDEFGH");
        run_case("truncate", 2, 2, str_q("ACBD"), 0, -1);
        send_msg("XY");
        run_case("after_trunc", 1, 2, str_q("XY"), 0, -1);

        send_msg("ABCDEF");
        run_case("reset_mid", 3, 2, str_q("ADBECF"), 0, 3);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("no valid after reset", 32'(bus.valid_o | bus.busy), 32'd0);
        end
        send_msg("ABCDEF");
        run_case("resend", 3, 2, str_q("ADBECF"), 0, -1);

        // 55 chars 0x20.. ; k -> row k%10, col k/10 -> source row*5+col
        long_msg = "";
        for (int i = 0; i < 55; i++) long_msg = {long_msg, string'(8'(8'h20 + i))};
        send_msg(long_msg);
        exp = {};
        for (int k = 0; k < 50; k++) exp.push_back(8'(8'h20 + (k % 10) * 5 + k / 10));
        run_case("overflow", 5, 10, exp, 1, -1);

        exp = {};
        run_case("zero_key", 0, 2, exp, 0, -1);
        exp = '{8'h00, 8'h00};
        run_case("empty_msg", 2, 1, exp, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
